// File: rtl/gcd_pkg.sv
// ============================================================================
// Module  : gcd_pkg
// Brief   : Shared constants for the GCD result display: segment patterns,
//           conversion FSM encoding and digit layout.
// Revision: 1.0 - initial release
// ============================================================================
`default_nettype none

package gcd_pkg;

  localparam int DIGITS = 3;

  // Conversion FSM encoding
  localparam logic [1:0] ST_IDLE   = 2'd0;
  localparam logic [1:0] ST_SHIFT  = 2'd1;
  localparam logic [1:0] ST_COMMIT = 2'd2;

  // Active-high segment patterns, bit order {g,f,e,d,c,b,a}
  localparam logic [6:0] SEG_0   = 7'h3F;
  localparam logic [6:0] SEG_1   = 7'h06;
  localparam logic [6:0] SEG_2   = 7'h5B;
  localparam logic [6:0] SEG_3   = 7'h4F;
  localparam logic [6:0] SEG_4   = 7'h66;
  localparam logic [6:0] SEG_5   = 7'h6D;
  localparam logic [6:0] SEG_6   = 7'h7D;
  localparam logic [6:0] SEG_7   = 7'h07;
  localparam logic [6:0] SEG_8   = 7'h7F;
  localparam logic [6:0] SEG_9   = 7'h6F;
  localparam logic [6:0] SEG_OFF = 7'h00;

  typedef struct packed {
    logic [3:0] hund;
    logic [3:0] tens;
    logic [3:0] ones;
  } bcd_t;

  function automatic logic [6:0] seg_decode(input logic [3:0] nib);
    logic [6:0] pat;
    case (nib)
      4'd0:    pat = SEG_0;
      4'd1:    pat = SEG_1;
      4'd2:    pat = SEG_2;
      4'd3:    pat = SEG_3;
      4'd4:    pat = SEG_4;
      4'd5:    pat = SEG_5;
      4'd6:    pat = SEG_6;
      4'd7:    pat = SEG_7;
      4'd8:    pat = SEG_8;
      4'd9:    pat = SEG_9;
      default: pat = SEG_OFF;
    endcase
    return pat;
  endfunction

endpackage

`default_nettype wire

// File: rtl/gcd_seg_display_bin2bcd.sv
// ============================================================================
// Module  : bin2bcd_dd
// Brief   : Sequential double-dabble converter, 8-bit binary to 3 BCD digits,
//           one shift per clock after a load.
// Revision: 1.0 - initial release
// ============================================================================
`default_nettype none

module bin2bcd_dd
  import gcd_pkg::*;
(
  input  logic        clk,
  input  logic        rst,
  input  logic        load,
  input  logic [7:0]  value,
  output logic        busy,
  output logic        done,
  output logic [11:0] bcd
);

  logic [19:0] r_shreg;
  logic [2:0]  r_cnt;
  logic        r_busy;
  logic [19:0] w_adj;

  // Add-3 correction on each BCD nibble; nibbles never carry into each other
  always_comb begin
    w_adj = r_shreg;
    for (int i = 0; i < DIGITS; i++) begin
      if (r_shreg[8+4*i +: 4] >= 4'd5)
        w_adj[8+4*i +: 4] = r_shreg[8+4*i +: 4] + 4'd3;
    end
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      r_shreg <= '0;
      r_cnt   <= '0;
      r_busy  <= 1'b0;
    end else if (load) begin
      r_shreg <= {12'h000, value};
      r_cnt   <= '0;
      r_busy  <= 1'b1;
    end else if (r_busy) begin
      r_shreg <= {w_adj[18:0], 1'b0};
      r_cnt   <= r_cnt + 3'd1;
      if (r_cnt == 3'd7)
        r_busy <= 1'b0;
    end
  end

  // done marks the clock on which the eighth shift happens
  assign done = r_busy && (r_cnt == 3'd7);
  assign busy = r_busy;
  assign bcd  = r_shreg[19:8];

endmodule

`default_nettype wire

// File: rtl/gcd_seg_display.sv
// ============================================================================
// Module  : gcd_seg_display
// Brief   : Converts the 8-bit GCD result to decimal and scans it onto a
//           3-digit multiplexed 7-segment display with leading-zero blanking.
// Revision: 1.0 - initial release
// ============================================================================
`default_nettype none

module gcd_seg_display
  import gcd_pkg::*;
#(
  parameter int REFRESH_DIV = 100000,
  parameter bit SEG_ACT_LOW = 1'b1
) (
  input  logic       clk,
  input  logic       rst,
  input  logic [7:0] value,
  output logic [6:0] seg,
  output logic [2:0] an,
  output logic       busy
);

  localparam int             PRE_W   = (REFRESH_DIV > 2) ? $clog2(REFRESH_DIV) : 1;
  localparam logic [PRE_W-1:0] PRE_MAX = PRE_W'(REFRESH_DIV - 1);
  localparam logic [6:0]     SEG_INV = {7{SEG_ACT_LOW}};
  localparam logic [2:0]     AN_INV  = {3{SEG_ACT_LOW}};

  logic [1:0]       r_state;
  logic [7:0]       r_last_val;
  bcd_t             r_disp;
  logic             r_busy;
  logic [PRE_W-1:0] r_pre;
  logic [1:0]       r_idx;

  logic             w_load;
  logic             w_conv_busy;
  logic             w_conv_done;
  logic [11:0]      w_conv_bcd;
  logic [3:0]       w_nib;
  logic             w_blank;
  logic [6:0]       w_seg;
  logic [2:0]       w_an;

  assign w_load = (r_state == ST_IDLE) && !w_conv_busy && (value != r_last_val);

  bin2bcd_dd u_bin2bcd (
    .clk   (clk),
    .rst   (rst),
    .load  (w_load),
    .value (value),
    .busy  (w_conv_busy),
    .done  (w_conv_done),
    .bcd   (w_conv_bcd)
  );

  // Changes arriving mid-conversion are picked up on the next IDLE compare
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      r_state    <= ST_IDLE;
      r_last_val <= 8'd0;
      r_disp     <= '0;
      r_busy     <= 1'b0;
    end else begin
      case (r_state)
        ST_IDLE: begin
          if (w_load) begin
            r_last_val <= value;
            r_busy     <= 1'b1;
            r_state    <= ST_SHIFT;
          end
        end
        ST_SHIFT: begin
          if (w_conv_done)
            r_state <= ST_COMMIT;
        end
        ST_COMMIT: begin
          r_disp  <= w_conv_bcd;
          r_busy  <= 1'b0;
          r_state <= ST_IDLE;
        end
        default: r_state <= ST_IDLE;
      endcase
    end
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      r_pre <= '0;
      r_idx <= 2'd0;
    end else if (r_pre == PRE_MAX) begin
      r_pre <= '0;
      r_idx <= (r_idx == 2'd2) ? 2'd0 : r_idx + 2'd1;
    end else begin
      r_pre <= r_pre + 1'b1;
    end
  end

  always_comb begin
    w_nib   = r_disp.ones;
    w_blank = 1'b0;
    w_an    = 3'b001;
    case (r_idx)
      2'd1: begin
        w_nib   = r_disp.tens;
        w_blank = (r_disp.hund == 4'd0) && (r_disp.tens == 4'd0);
        w_an    = 3'b010;
      end
      2'd2: begin
        w_nib   = r_disp.hund;
        w_blank = (r_disp.hund == 4'd0);
        w_an    = 3'b100;
      end
      default: ;
    endcase
    w_seg = w_blank ? SEG_OFF : seg_decode(w_nib);
    if (w_blank)
      w_an = 3'b000;
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      seg <= SEG_OFF ^ SEG_INV;
      an  <= 3'b000 ^ AN_INV;
    end else begin
      seg <= w_seg ^ SEG_INV;
      an  <= w_an ^ AN_INV;
    end
  end

  assign busy = r_busy;

endmodule

`default_nettype wire

// File: tb/tb_gcd_seg_display.sv
// ============================================================================
// Module  : tb_gcd_seg_display
// Brief   : Directed self-checking bench for gcd_seg_display (REFRESH_DIV=4,
//           active-low outputs).
// Revision: 1.0 - initial release
// ============================================================================
`default_nettype none

module tb_gcd_seg_display;

  localparam logic [6:0] P0 = 7'h3F, P1 = 7'h06, P2 = 7'h5B, P4 = 7'h66;
  localparam logic [6:0] P5 = 7'h6D, P7 = 7'h07, P9 = 7'h6F, PB = 7'h00;

  logic       clk = 1'b0;
  logic       rst = 1'b1;
  logic [7:0] value = 8'd0;
  logic [6:0] seg;
  logic [2:0] an;
  logic       busy;

  int n_checks = 0;
  int n_errors = 0;

  gcd_seg_display #(
    .REFRESH_DIV (4),
    .SEG_ACT_LOW (1'b1)
  ) dut (
    .clk   (clk),
    .rst   (rst),
    .value (value),
    .seg   (seg),
    .an    (an),
    .busy  (busy)
  );

  always #5 clk = ~clk;

  task automatic check_val(input string tag, input logic [31:0] got, input logic [31:0] exp);
    n_checks++;
    if (got !== exp) begin
      n_errors++;
      $display("FAIL %s got %0h exp %0h", tag, got, exp);
    end
  endtask

  // Watch one full scan (3 slots x 4 clk) and record what each digit shows
  task automatic capture(output logic [6:0] h, output logic [6:0] t,
                         output logic [6:0] o, output logic bad);
    h = 7'h7F; t = 7'h7F; o = 7'h7F; bad = 1'b0;
    for (int i = 0; i < 12; i++) begin
      @(negedge clk);
      case (an)
        3'b110:  o = seg;
        3'b101:  t = seg;
        3'b011:  h = seg;
        3'b111:  if (seg !== 7'h7F) bad = 1'b1;
        default: bad = 1'b1;
      endcase
    end
  endtask

  task automatic show(input string tag, input logic [6:0] eh,
                      input logic [6:0] et, input logic [6:0] eo);
    logic [6:0] h, t, o, xh, xt, xo;
    logic       bad;
    capture(h, t, o, bad);
    xh = ~eh; xt = ~et; xo = ~eo;
    check_val({tag, "_hund"}, h, xh);
    check_val({tag, "_tens"}, t, xt);
    check_val({tag, "_ones"}, o, xo);
    check_val({tag, "_blank_ok"}, bad, 1'b0);
  endtask

  task automatic apply_value(input logic [7:0] v);
    @(negedge clk);
    value = v;
    repeat (11) @(negedge clk);
    check_val("conv_idle", busy, 1'b0);
  endtask

  initial begin
    logic [2:0] prev;
    logic       found;

    // Reset state
    repeat (3) @(negedge clk);
    check_val("rst_seg", seg, 7'h7F);
    check_val("rst_an", an, 3'b111);
    check_val("rst_busy", busy, 1'b0);
    rst = 1'b0;
    @(negedge clk);
    check_val("first_an", an, 3'b110);
    check_val("first_seg", seg, 7'h40);
    check_val("zero_busy", busy, 1'b0);
    show("v0", PB, PB, P0);

    // Latency 0 -> 255
    @(negedge clk);
    value = 8'd255;
    @(negedge clk);
    check_val("busy_e0", busy, 1'b1);
    repeat (8) @(negedge clk);
    check_val("busy_e8", busy, 1'b1);
    @(negedge clk);
    check_val("busy_e9", busy, 1'b0);

    // Scan order with all digits lit
    prev = an;
    found = 1'b0;
    for (int i = 0; i < 20 && !found; i++) begin
      @(negedge clk);
      if (an == 3'b110 && prev != 3'b110) found = 1'b1;
      prev = an;
    end
    check_val("scan_sync", found, 1'b1);
    check_val("scan_an0", an, 3'b110);
    check_val("scan_seg0", seg, 7'h12);
    repeat (4) @(negedge clk);
    check_val("scan_an1", an, 3'b101);
    check_val("scan_seg1", seg, 7'h12);
    repeat (4) @(negedge clk);
    check_val("scan_an2", an, 3'b011);
    check_val("scan_seg2", seg, 7'h24);
    repeat (4) @(negedge clk);
    check_val("scan_wrap", an, 3'b110);

    apply_value(8'd7);
    show("v7", PB, PB, P7);
    apply_value(8'd40);
    show("v40", PB, P4, P0);
    apply_value(8'd105);
    show("v105", P1, P0, P5);

    // Change to 200 at E3 of the conversion of 12
    @(negedge clk);
    value = 8'd12;
    repeat (3) @(negedge clk);
    value = 8'd200;
    repeat (7) @(negedge clk);
    check_val("re_e9_busy", busy, 1'b0);
    @(negedge clk);
    check_val("re_e10_busy", busy, 1'b1);
    repeat (8) @(negedge clk);
    check_val("re_e18_busy", busy, 1'b1);
    @(negedge clk);
    check_val("re_e19_busy", busy, 1'b0);
    show("v200", P2, P0, P0);

    // Async reset in the middle of a conversion
    @(negedge clk);
    value = 8'd99;
    repeat (4) @(negedge clk);
    rst = 1'b1;
    #1;
    check_val("mid_rst_seg", seg, 7'h7F);
    check_val("mid_rst_an", an, 3'b111);
    check_val("mid_rst_busy", busy, 1'b0);
    @(negedge clk);
    rst = 1'b0;
    repeat (11) @(negedge clk);
    check_val("post_rst_idle", busy, 1'b0);
    show("v99", PB, P9, P9);

    $display("CHECKS %0d ERRORS %0d", n_checks, n_errors);
    $finish;
  end

  initial begin
    #100000;
    $display("FAIL timeout got running exp finished");
    $fatal(1, "timeout");
  end

endmodule

`default_nettype wire
